roi_norm_buffer: RTL and testbench



---
 rtl/roi_norm_if.sv | 27 ++
 rtl/roi_norm_buffer.sv | 255 +++++++++++++++++++++++++
 tb/tb_roi_norm_buffer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/roi_norm_if.sv
// Pixel-in / normalised-pixel-out bundle for roi_norm_buffer.
// slave = buffer side, master = producer/consumer side.
interface roi_norm_if #(
    parameter int unsigned IN_WIDTH      = 12,
    parameter int unsigned OUT_WIDTH     = 12,
    parameter int unsigned NUM_PER_CYCLE = 2
);
    logic [NUM_PER_CYCLE-1:0][IN_WIDTH-1:0]  din;
    logic                                    din_valid;
    logic                                    din_ready;
    logic [IN_WIDTH-1:0]                     max_in;
    logic [NUM_PER_CYCLE-1:0][OUT_WIDTH-1:0] dout;
    logic                                    dout_valid;
    logic                                    dout_last;
    logic                                    busy;
    logic                                    frame_done;

    modport master (
        output din, din_valid, max_in,
        input  din_ready, dout, dout_valid, dout_last, busy, frame_done
    );

    modport slave (
        input  din, din_valid, max_in,
        output din_ready, dout, dout_valid, dout_last, busy, frame_done
    );
endinterface

// File: rtl/roi_norm_buffer.sv
// Frame buffer that replays a stored ROI divided by the frame maximum (Q0.OUT_WIDTH).
// Optional saturation counter port enabled by ROI_NORM_SAT_COUNT_EN.
module roi_norm_buffer #(
    parameter int unsigned ROI_SIZE      = 480,
    parameter int unsigned IN_WIDTH      = 12,
    parameter int unsigned OUT_WIDTH     = 12,
    parameter int unsigned MASK_SIZE     = 6,
    parameter int unsigned NUM_PER_CYCLE = 2,
    parameter int unsigned BORDER_MODE   = 0
) (
    input  logic clk,
    input  logic rst,
`ifdef ROI_NORM_SAT_COUNT_EN
    output logic [$clog2(ROI_SIZE*ROI_SIZE+1)-1:0] sat_count,
`endif
    roi_norm_if.slave bus
);
    localparam int unsigned DEPTH     = ROI_SIZE * ROI_SIZE / NUM_PER_CYCLE;
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned PW        = NUM_PER_CYCLE * IN_WIDTH;
    localparam int unsigned BEATS_ROW = ROI_SIZE / NUM_PER_CYCLE;
    localparam int unsigned RD_COLS   = (BORDER_MODE != 0) ? BEATS_ROW
                                        : (ROI_SIZE - 2 * MASK_SIZE) / NUM_PER_CYCLE;
    localparam int unsigned RD_ROWS   = (BORDER_MODE != 0) ? ROI_SIZE : ROI_SIZE - 2 * MASK_SIZE;
    localparam int unsigned ROW_JUMP  = (BORDER_MODE != 0) ? 1 : 2 * MASK_SIZE / NUM_PER_CYCLE + 1;
    localparam int unsigned RD_START  = (BORDER_MODE != 0) ? 0
                                        : MASK_SIZE * BEATS_ROW + MASK_SIZE / NUM_PER_CYCLE;

    typedef enum logic [0:0] {StFill, StDrain} state_e;

    state_e          state_q;
    logic            din_ready_q, busy_q, frame_done_q, rd_done_q;
    logic [AW-1:0]   wr_addr_q, rd_addr_q, rd_row_q, rd_col_q;
    logic [IN_WIDTH-1:0] max_q;

    logic [PW-1:0]   mem [DEPTH];
    logic [PW-1:0]   ram_q;
    logic            v0_q, last0_q;
    logic [NUM_PER_CYCLE-1:0] zero0_q, zero_mask;

    // Divider stage s holds the quotient after s+1 restoring steps.
    logic [IN_WIDTH-1:0]      rem_q [OUT_WIDTH][NUM_PER_CYCLE];
    logic [IN_WIDTH-1:0]      rem_d [OUT_WIDTH][NUM_PER_CYCLE];
    logic [OUT_WIDTH-1:0]     quo_q [OUT_WIDTH][NUM_PER_CYCLE];
    logic [OUT_WIDTH-1:0]     quo_d [OUT_WIDTH][NUM_PER_CYCLE];
    logic [NUM_PER_CYCLE-1:0] ovf_q [OUT_WIDTH];
    logic [NUM_PER_CYCLE-1:0] ovf_d [OUT_WIDTH];
    logic [NUM_PER_CYCLE-1:0] zero_q [OUT_WIDTH];
    logic [NUM_PER_CYCLE-1:0] zero_d [OUT_WIDTH];
    logic [OUT_WIDTH-1:0]     vld_q, vld_d, last_q, last_d;

    logic [NUM_PER_CYCLE-1:0][OUT_WIDTH-1:0] dout_q;
    logic dout_valid_q, dout_last_q;

    logic accept, last_wr, rd_en, col_end, row_end;

    assign accept  = bus.din_valid && din_ready_q;
    assign last_wr = (wr_addr_q == AW'(DEPTH - 1));
    assign rd_en   = (state_q == StDrain) && !rd_done_q;
    assign col_end = (rd_col_q == AW'(RD_COLS - 1));
    assign row_end = (rd_row_q == AW'(RD_ROWS - 1));

    assign bus.din_ready  = din_ready_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_last  = dout_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFill;
            din_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            rd_done_q    <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            rd_row_q     <= '0;
            rd_col_q     <= '0;
            max_q        <= '0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                StFill: begin
                    if (accept) begin
                        if (last_wr) begin
                            wr_addr_q   <= '0;
                            max_q       <= bus.max_in;
                            state_q     <= StDrain;
                            din_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            rd_addr_q   <= AW'(RD_START);
                            rd_row_q    <= '0;
                            rd_col_q    <= '0;
                            rd_done_q   <= 1'b0;
                        end else begin
                            wr_addr_q <= wr_addr_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (rd_en) begin
                        if (col_end) begin
                            rd_col_q <= '0;
                            if (row_end) begin
                                rd_done_q <= 1'b1;
                            end else begin
                                rd_row_q  <= rd_row_q + 1'b1;
                                rd_addr_q <= rd_addr_q + AW'(ROW_JUMP);
                            end
                        end else begin
                            rd_col_q  <= rd_col_q + 1'b1;
                            rd_addr_q <= rd_addr_q + 1'b1;
                        end
                    end
                    // Last beat is on dout now, so the pipeline is empty next cycle.
                    if (dout_valid_q && dout_last_q) begin
                        state_q      <= StFill;
                        din_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        rd_done_q    <= 1'b0;
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_addr_q] <= bus.din;
        ram_q <= mem[rd_addr_q];
    end

    always_comb begin
        logic [31:0] row, col;
        zero_mask = '0;
        row = 32'(rd_row_q);
        for (int l = 0; l < NUM_PER_CYCLE; l++) begin
            col = 32'(rd_col_q) * NUM_PER_CYCLE + 32'(l);
            zero_mask[l] = (max_q == '0);
            if (BORDER_MODE != 0 && (row < MASK_SIZE || row >= ROI_SIZE - MASK_SIZE ||
                                     col < MASK_SIZE || col >= ROI_SIZE - MASK_SIZE)) begin
                zero_mask[l] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q    <= 1'b0;
            last0_q <= 1'b0;
            zero0_q <= '0;
        end else begin
            v0_q    <= rd_en;
            last0_q <= rd_en && col_end && row_end;
            zero0_q <= zero_mask;
        end
    end

    function automatic logic [IN_WIDTH:0] div_step(input logic [IN_WIDTH-1:0] r,
                                                   input logic [IN_WIDTH-1:0] m);
        logic [IN_WIDTH:0] t;
        t = {r, 1'b0};
        if (t >= {1'b0, m}) begin
            t = t - {1'b0, m};
            return {t[IN_WIDTH-1:0], 1'b1};
        end
        return {t[IN_WIDTH-1:0], 1'b0};
    endfunction

    always_comb begin
        logic [IN_WIDTH:0]   step;
        logic [IN_WIDTH-1:0] pix;
        rem_d  = '{default: '0};
        quo_d  = '{default: '0};
        ovf_d  = '{default: '0};
        zero_d = '{default: '0};
        vld_d  = {vld_q[OUT_WIDTH-2:0], v0_q};
        last_d = {last_q[OUT_WIDTH-2:0], last0_q};
        zero_d[0] = zero0_q;
        for (int l = 0; l < NUM_PER_CYCLE; l++) begin
            pix          = ram_q[l*IN_WIDTH +: IN_WIDTH];
            step         = div_step(pix, max_q);
            rem_d[0][l]  = step[IN_WIDTH:1];
            quo_d[0][l]  = OUT_WIDTH'(step[0]);
            // Quotient would need more than OUT_WIDTH bits; remainder path is don't-care.
            ovf_d[0][l]  = (pix >= max_q);
        end
        for (int s = 1; s < OUT_WIDTH; s++) begin
            ovf_d[s]  = ovf_q[s-1];
            zero_d[s] = zero_q[s-1];
            for (int l = 0; l < NUM_PER_CYCLE; l++) begin
                step        = div_step(rem_q[s-1][l], max_q);
                rem_d[s][l] = step[IN_WIDTH:1];
                quo_d[s][l] = {quo_q[s-1][l][OUT_WIDTH-2:0], step[0]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q        <= '{default: '0};
            quo_q        <= '{default: '0};
            ovf_q        <= '{default: '0};
            zero_q       <= '{default: '0};
            vld_q        <= '0;
            last_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            ovf_q        <= ovf_d;
            zero_q       <= zero_d;
            vld_q        <= vld_d;
            last_q       <= last_d;
            dout_valid_q <= vld_q[OUT_WIDTH-1];
            dout_last_q  <= vld_q[OUT_WIDTH-1] && last_q[OUT_WIDTH-1];
            for (int l = 0; l < NUM_PER_CYCLE; l++) begin
                if (zero_q[OUT_WIDTH-1][l])     dout_q[l] <= '0;
                else if (ovf_q[OUT_WIDTH-1][l]) dout_q[l] <= '1;
                else                            dout_q[l] <= quo_q[OUT_WIDTH-1][l];
            end
        end
    end

`ifdef ROI_NORM_SAT_COUNT_EN
    localparam int unsigned SW = $clog2(ROI_SIZE * ROI_SIZE + 1);
    logic [SW-1:0] sat_cnt_q, sat_inc;

    always_comb begin
        sat_inc = '0;
        for (int l = 0; l < NUM_PER_CYCLE; l++) begin
            if (vld_q[OUT_WIDTH-1] && ovf_q[OUT_WIDTH-1][l] && !zero_q[OUT_WIDTH-1][l]) begin
                sat_inc = sat_inc + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else if (state_q == StFill && accept && last_wr) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_q + sat_inc;
        end
    end

    assign sat_count = sat_cnt_q;
`endif
endmodule

// File: tb/tb_roi_norm_buffer.sv
// Randomised scoreboard bench for roi_norm_buffer: BORDER_MODE 0 and 1 instances share stimulus.
module tb_roi_norm_buffer;
    localparam int ROI = 8;
    localparam int M   = 2;

    logic clk = 1'b0;
    logic rst;
    logic [1:0][11:0] din;
    logic din_valid;
    logic [11:0] max_in;

    roi_norm_if #(.IN_WIDTH(12), .OUT_WIDTH(12), .NUM_PER_CYCLE(2)) bus0 ();
    roi_norm_if #(.IN_WIDTH(12), .OUT_WIDTH(12), .NUM_PER_CYCLE(2)) bus1 ();

    assign bus0.din = din;
    assign bus0.din_valid = din_valid;
    assign bus0.max_in = max_in;
    assign bus1.din = din;
    assign bus1.din_valid = din_valid;
    assign bus1.max_in = max_in;

`ifdef ROI_NORM_SAT_COUNT_EN
    logic [6:0] sat0, sat1;
    int sat_exp;
`endif

    roi_norm_buffer #(.ROI_SIZE(ROI), .IN_WIDTH(12), .OUT_WIDTH(12), .MASK_SIZE(M),
                      .NUM_PER_CYCLE(2), .BORDER_MODE(0)) dut0 (
        .clk(clk),
        .rst(rst),
`ifdef ROI_NORM_SAT_COUNT_EN
        .sat_count(sat0),
`endif
        .bus(bus0)
    );

    roi_norm_buffer #(.ROI_SIZE(ROI), .IN_WIDTH(12), .OUT_WIDTH(12), .MASK_SIZE(M),
                      .NUM_PER_CYCLE(2), .BORDER_MODE(1)) dut1 (
        .clk(clk),
        .rst(rst),
`ifdef ROI_NORM_SAT_COUNT_EN
        .sat_count(sat1),
`endif
        .bus(bus1)
    );

    always #5 clk = ~clk;

    logic dv[2], dl[2], fd[2], rdy[2], bsy[2];
    logic [23:0] dd[2];
    assign dv[0] = bus0.dout_valid;  assign dv[1] = bus1.dout_valid;
    assign dl[0] = bus0.dout_last;   assign dl[1] = bus1.dout_last;
    assign fd[0] = bus0.frame_done;  assign fd[1] = bus1.frame_done;
    assign rdy[0] = bus0.din_ready;  assign rdy[1] = bus1.din_ready;
    assign bsy[0] = bus0.busy;       assign bsy[1] = bus1.busy;
    assign dd[0] = bus0.dout;        assign dd[1] = bus1.dout;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pix[ROI][ROI];
    logic [24:0] exp_q[2][$];
    int out_beats[2], fd_count[2], drain_start[2];
    bit first_pend[2], bsy_prev[2], last_prev[2];
    int frames_exp = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int norm(input int p, input int m);
        int q;
        if (m == 0) return 0;
        q = (p * 4096) / m;
        return (q > 4095) ? 4095 : q;
    endfunction

    function automatic bit interior(input int r, input int c);
        return r >= M && r < ROI - M && c >= M && c < ROI - M;
    endfunction

    // Reference: raster walk of the stored frame, interior only (mode 0) or full with zeroed border.
    task automatic push_frame(input int maxv);
        logic [24:0] e;
        for (int mode = 0; mode < 2; mode++) begin
            for (int r = 0; r < ROI; r++) begin
                for (int c = 0; c < ROI; c += 2) begin
                    if (mode == 0 && !(interior(r, c) && interior(r, c + 1))) continue;
                    e = '0;
                    for (int l = 0; l < 2; l++) begin
                        if (interior(r, c + l)) e[l*12 +: 12] = 12'(norm(pix[r][c+l], maxv));
                    end
                    exp_q[mode].push_back(e);
                end
            end
            e = exp_q[mode].pop_back();
            e[24] = 1'b1;
            exp_q[mode].push_back(e);
        end
`ifdef ROI_NORM_SAT_COUNT_EN
        sat_exp = 0;
        for (int r = 0; r < ROI; r++)
            for (int c = 0; c < ROI; c++)
                if (interior(r, c) && maxv != 0 && pix[r][c] >= maxv) sat_exp++;
`endif
    endtask

    task automatic send_frame(input int maxv, input bit hold);
        int r, c;
        for (int b = 0; b < ROI * ROI / 2; b++) begin
            r = b / (ROI / 2);
            c = (b % (ROI / 2)) * 2;
            if ($urandom_range(0, 3) == 0) begin
                din_valid = 1'b0;
                din = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))};
                max_in = 12'($urandom_range(0, 4095));
                @(negedge clk); #1;
            end
            din[0] = 12'(pix[r][c]);
            din[1] = 12'(pix[r][c+1]);
            din_valid = 1'b1;
            max_in = (b == ROI * ROI / 2 - 1) ? 12'(maxv) : 12'($urandom_range(0, 4095));
            @(negedge clk); #1;
        end
        if (hold) begin
            din = {12'hFFF, 12'hFFF};
            repeat (15) begin
                max_in = 12'($urandom_range(0, 4095));
                @(negedge clk); #1;
            end
        end
        din_valid = 1'b0;
        max_in = 12'($urandom_range(0, 4095));
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 400; k++) begin
            if (rdy[0] && rdy[1] && exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
            @(negedge clk); #1;
        end
        chk("idle wait in bound", int'(k < 400), 1);
    endtask

    task automatic fill(input int kind, input int maxv);
        for (int r = 0; r < ROI; r++)
            for (int c = 0; c < ROI; c++)
                case (kind)
                    0: pix[r][c] = 8 * r + c;
                    1: pix[r][c] = 100;
                    2: pix[r][c] = $urandom_range(0, 4095);
                    default: pix[r][c] = $urandom_range(0, maxv);
                endcase
    endtask

    task automatic run_frame(input int kind, input int maxv, input bit hold);
        wait_idle();
        fill(kind, maxv);
        push_frame(maxv);
        send_frame(maxv, hold);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        logic [24:0] e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (bsy[i] && !bsy_prev[i]) begin
                    drain_start[i] = cyc;
                    first_pend[i] = 1'b1;
                end
                if (bsy[i]) chk($sformatf("dut%0d din_ready low in drain", i), int'(rdy[i]), 0);
                if (dv[i]) begin
                    if (first_pend[i]) begin
                        chk($sformatf("dut%0d first-beat latency", i), cyc - drain_start[i], 14);
                        first_pend[i] = 1'b0;
                    end
                    if (exp_q[i].size() == 0) begin
                        chk($sformatf("dut%0d unexpected beat", i), 1, 0);
                    end else begin
                        e = exp_q[i].pop_front();
                        chk($sformatf("dut%0d dout", i), int'(dd[i]), int'(e[23:0]));
                        chk($sformatf("dut%0d dout_last", i), int'(dl[i]), int'(e[24]));
                    end
                    out_beats[i]++;
                end
                if (fd[i]) begin
                    chk($sformatf("dut%0d frame_done after last", i), int'(last_prev[i]), 1);
                    chk($sformatf("dut%0d din_ready with frame_done", i), int'(rdy[i]), 1);
`ifdef ROI_NORM_SAT_COUNT_EN
                    chk($sformatf("dut%0d sat_count", i), int'(i == 0 ? sat0 : sat1), sat_exp);
`endif
                    fd_count[i]++;
                end
                last_prev[i] = dv[i] && dl[i];
                bsy_prev[i] = bsy[i];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, k;
        rst = 1'b1;
        din = '0;
        din_valid = 1'b0;
        max_in = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d reset dout_valid", i), int'(dv[i]), 0);
            chk($sformatf("dut%0d reset dout", i), int'(dd[i]), 0);
            chk($sformatf("dut%0d reset dout_last", i), int'(dl[i]), 0);
            chk($sformatf("dut%0d reset busy", i), int'(bsy[i]), 0);
            chk($sformatf("dut%0d reset frame_done", i), int'(fd[i]), 0);
            chk($sformatf("dut%0d reset din_ready", i), int'(rdy[i]), 1);
        end
        #1 rst = 1'b0;
        @(negedge clk); #1;

        run_frame(0, 63, 1'b0);  frames_exp++;   // ramp
        run_frame(1, 50, 1'b0);  frames_exp++;   // all saturate
        run_frame(0, 0, 1'b0);   frames_exp++;   // max == 0
        run_frame(0, 63, 1'b1);  frames_exp++;   // din_valid held through drain

        // Reset after the third output beat; the partial frame must vanish.
        base = out_beats[0];
        run_frame(0, 63, 1'b0);
        for (k = 0; k < 200; k++) begin
            if (out_beats[0] >= base + 3) break;
            @(negedge clk); #1;
        end
        chk("third beat before reset in bound", int'(k < 200), 1);
        rst = 1'b1;
        exp_q[0].delete();
        exp_q[1].delete();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d dout_valid after reset", i), int'(dv[i]), 0);
            chk($sformatf("dut%0d busy after reset", i), int'(bsy[i]), 0);
            chk($sformatf("dut%0d din_ready after reset", i), int'(rdy[i]), 1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;

        run_frame(0, 63, 1'b0);  frames_exp++;
        for (int f = 0; f < 4; f++) begin
            k = (f == 0) ? 1 : $urandom_range(1, 4095);
            run_frame((f % 2 == 0) ? 2 : 3, k, 1'b0);
            frames_exp++;
        end
        wait_idle();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d frame_done count", i), fd_count[i], frames_exp);
            chk($sformatf("dut%0d leftover expected beats", i), exp_q[i].size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
